// File: rtl/memory_access_unit.sv
// Load/store unit: aligns and sign/zero-extends loads, lane-replicates stores, and rejects misaligned requests.
// Optional wait-state watchdog compiled in with `define MEM_TIMEOUT_EN.
module memory_access_unit #(
    parameter int DATA_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Req,
    input  logic                 WrEn,
    input  logic [1:0]           Size,
    input  logic                 Signed,
    input  logic [DATA_SIZE-1:0] Addr,
    input  logic [DATA_SIZE-1:0] StoreData,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Error,
    output logic [DATA_SIZE-1:0] LoadData,
    output logic                 MdrEnable,
    output logic [DATA_SIZE-1:0] MemAddr,
    output logic [DATA_SIZE-1:0] MemWData,
    output logic [3:0]           MemBE,
    output logic                 MemRead,
    output logic                 MemWrite,
    input  logic                 MemReady,
    input  logic [DATA_SIZE-1:0] MemRData
);

    if (DATA_SIZE != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("memory_access_unit: DATA_SIZE must be 32 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic                 wr_q;
    logic [1:0]           size_q;
    logic                 sgn_q;
    logic [DATA_SIZE-1:0] addr_q;
    logic [DATA_SIZE-1:0] sd_q;
    logic                 err_q;
    logic [DATA_SIZE-1:0] load_q;
    logic                 timeout_hit;

    function automatic logic is_illegal(input logic [1:0] sz, input logic [1:0] off);
        is_illegal = (sz == 2'b11) || (sz == 2'b01 && off[0]) || (sz == 2'b10 && off != 2'b00);
    endfunction

    function automatic logic [DATA_SIZE-1:0] extract_load(input logic [DATA_SIZE-1:0] rdata,
                                                          input logic [1:0] sz,
                                                          input logic [1:0] off,
                                                          input logic sgn);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (sz)
            2'b00:   extract_load = sgn ? DATA_SIZE'(b) : DATA_SIZE'($unsigned(b));
            2'b01:   extract_load = sgn ? DATA_SIZE'(h) : DATA_SIZE'($unsigned(h));
            default: extract_load = rdata;
        endcase
    endfunction

    function automatic logic [DATA_SIZE-1:0] store_lanes(input logic [1:0] sz,
                                                         input logic [DATA_SIZE-1:0] sd);
        case (sz)
            2'b00:   store_lanes = {4{sd[7:0]}};
            2'b01:   store_lanes = {2{sd[15:0]}};
            default: store_lanes = sd;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic wr, input logic [1:0] sz,
                                                input logic [1:0] off);
        if (!wr) begin
            byte_enables = 4'b1111;
        end else begin
            case (sz)
                2'b00:   byte_enables = 4'b0001 << off;
                2'b01:   byte_enables = off[1] ? 4'b1100 : 4'b0011;
                default: byte_enables = 4'b1111;
            endcase
        end
    endfunction

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] wait_cnt;

    // Counter is held at zero outside ACCESS, so it starts clean on every entry.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wait_cnt <= '0;
        end else if (state != ACCESS) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == ACCESS) && !MemReady && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        Busy      = (state != IDLE);
        Done      = (state == DONE);
        Error     = (state == DONE) && err_q;
        MdrEnable = (state == DONE) && !err_q && !wr_q;
        MemRead   = (state == ACCESS) && !wr_q;
        MemWrite  = (state == ACCESS) && wr_q;
        MemBE     = 4'b0000;
        case (state)
            IDLE: begin
                if (Req) begin
                    state_nx = is_illegal(Size, Addr[1:0]) ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                MemBE = byte_enables(wr_q, size_q, addr_q[1:0]);
                if (MemReady || timeout_hit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Request capture, error latch and load result register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_q   <= 1'b0;
            size_q <= 2'b00;
            sgn_q  <= 1'b0;
            addr_q <= '0;
            sd_q   <= '0;
            err_q  <= 1'b0;
            load_q <= '0;
        end else begin
            if (state == IDLE && Req) begin
                wr_q   <= WrEn;
                size_q <= Size;
                sgn_q  <= Signed;
                addr_q <= Addr;
                sd_q   <= StoreData;
                err_q  <= is_illegal(Size, Addr[1:0]);
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
            if (state == ACCESS && MemReady && !wr_q) begin
                load_q <= extract_load(MemRData, size_q, addr_q[1:0], sgn_q);
            end
        end
    end

    assign MemAddr  = {addr_q[DATA_SIZE-1:2], 2'b00};
    assign MemWData = store_lanes(size_q, sd_q);
    assign LoadData = load_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed self-checking bench for memory_access_unit.
module tb_memory_access_unit;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Req = 1'b0;
    logic        WrEn = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic        Signed = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] StoreData = '0;
    logic        Busy, Done, Error, MdrEnable, MemRead, MemWrite;
    logic [31:0] LoadData, MemAddr, MemWData;
    logic [3:0]  MemBE;
    logic        MemReady = 1'b0;
    logic [31:0] MemRData = '0;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_load = '0;

    memory_access_unit #(.DATA_SIZE(32), .TIMEOUT_CYCLES(4)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .WrEn(WrEn), .Size(Size), .Signed(Signed),
        .Addr(Addr), .StoreData(StoreData), .Busy(Busy), .Done(Done), .Error(Error),
        .LoadData(LoadData), .MdrEnable(MdrEnable), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemBE(MemBE), .MemRead(MemRead), .MemWrite(MemWrite), .MemReady(MemReady),
        .MemRData(MemRData)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] sd);
        Req = 1'b1; WrEn = wr; Size = sz; Signed = sg; Addr = ad; StoreData = sd;
        step();
        Req = 1'b0;
    endtask

    task automatic access(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [31:0] sd, input logic [31:0] rd,
                          input int waits, input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_load);
        MemReady = 1'b0;
        MemRData = rd;
        issue(wr, sz, sg, ad, sd);
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) MemReady = 1'b1;
            @(negedge Clk);
            check({tag, ".rd"}, 32'(MemRead), 32'(!wr));
            check({tag, ".wr"}, 32'(MemWrite), 32'(wr));
            check({tag, ".addr"}, MemAddr, {ad[31:2], 2'b00});
            check({tag, ".be"}, 32'(MemBE), 32'(exp_be));
            if (wr) check({tag, ".wdata"}, MemWData, exp_wdata);
            check({tag, ".done_early"}, 32'(Done), 32'd0);
            step();
        end
        MemReady = 1'b0;
        @(negedge Clk);
        check({tag, ".done"}, 32'(Done), 32'd1);
        check({tag, ".err"}, 32'(Error), 32'd0);
        check({tag, ".mdr"}, 32'(MdrEnable), 32'(!wr));
        check({tag, ".strobe_off"}, 32'(MemRead | MemWrite), 32'd0);
        check({tag, ".load"}, LoadData, exp_load);
        last_load = exp_load;
        step();
        @(negedge Clk);
        check({tag, ".idle"}, 32'(Busy | Done), 32'd0);
    endtask

    task automatic err_access(input string tag, input logic wr, input logic [1:0] sz,
                              input logic [31:0] ad);
        issue(wr, sz, 1'b0, ad, 32'h5555_AAAA);
        @(negedge Clk);
        check({tag, ".done"}, 32'(Done), 32'd1);
        check({tag, ".err"}, 32'(Error), 32'd1);
        check({tag, ".strobe"}, 32'(MemRead | MemWrite), 32'd0);
        check({tag, ".mdr"}, 32'(MdrEnable), 32'd0);
        check({tag, ".load"}, LoadData, last_load);
        step();
        @(negedge Clk);
        check({tag, ".after"}, 32'({Busy, Done, Error}), 32'd0);
    endtask

    initial begin
        int n;
        int first_done;
        int second_done;

        #2;
        check("rst.ctrl", 32'({Busy, Done, Error, MdrEnable, MemRead, MemWrite}), 32'd0);
        check("rst.load", LoadData, 32'd0);
        check("rst.addr", MemAddr, 32'd0);
        check("rst.wdata", MemWData, 32'd0);
        check("rst.be", 32'(MemBE), 32'd0);
        step();
        step();
        Rst = 1'b0;

        access("ldb_s", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF_1234, 0, 32'h0, 4'hF, 32'hFFFF_FF80);
        access("ldb_u", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h80FF_1234, 0, 32'h0, 4'hF, 32'h0000_0012);
        access("ldb_u2", 1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 32'h80FF_1234, 1, 32'h0, 4'hF, 32'h0000_00FF);
        access("ldh_s", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80FF_1234, 0, 32'h0, 4'hF, 32'hFFFF_80FF);
        access("ldh_u", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h80FF_9234, 0, 32'h0, 4'hF, 32'h0000_9234);
        access("ldw", 1'b0, 2'b10, 1'b1, 32'h200, 32'h0, 32'hCAFE_F00D, 2, 32'h0, 4'hF, 32'hCAFE_F00D);
        access("sth", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, 32'h0, 3, 32'hBEEF_BEEF, 4'b1100, last_load);
        access("sth_lo", 1'b1, 2'b01, 1'b0, 32'h20, 32'h1234_5678, 32'h0, 0, 32'h5678_5678, 4'b0011, last_load);
        access("stb", 1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_56A5, 32'h0, 0, 32'hA5A5_A5A5, 4'b0010, last_load);
        access("stb3", 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_003C, 32'h0, 1, 32'h3C3C_3C3C, 4'b1000, last_load);
        access("stw", 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'h0, 0, 32'hDEAD_BEEF, 4'hF, last_load);

        err_access("ldw_mis", 1'b0, 2'b10, 32'h41);
        err_access("ldw_mis2", 1'b0, 2'b10, 32'h42);
        err_access("sth_mis", 1'b1, 2'b01, 32'h05);
        err_access("rsvd", 1'b0, 2'b11, 32'h100);

        // Req held high across two back-to-back loads.
        MemReady = 1'b1;
        MemRData = 32'h0000_00AB;
        WrEn = 1'b0; Size = 2'b00; Signed = 1'b0; Addr = 32'h300; StoreData = '0;
        Req = 1'b1;
        n = 0; first_done = 0; second_done = 0;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 5) Req = 1'b0;
            @(negedge Clk);
            if (Done) begin
                if (n == 0) first_done = c;
                else if (n == 1) second_done = c;
                n++;
            end
        end
        MemReady = 1'b0;
        check("b2b.count", 32'(n), 32'd2);
        check("b2b.first", 32'(first_done), 32'd2);
        check("b2b.second", 32'(second_done), 32'd5);
        check("b2b.load", LoadData, 32'h0000_00AB);
        last_load = 32'h0000_00AB;

        // Reset in the middle of an access.
        step();
        MemRData = 32'h1111_2222;
        issue(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
        @(negedge Clk);
        check("rstmid.rd_before", 32'(MemRead), 32'd1);
        #2 Rst = 1'b1;
        #1;
        check("rstmid.rd_async", 32'(MemRead), 32'd0);
        check("rstmid.busy", 32'(Busy), 32'd0);
        check("rstmid.load", LoadData, 32'd0);
        step();
        Rst = 1'b0;
        last_load = '0;
        MemReady = 1'b1;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            if (Done) n++;
            step();
        end
        MemReady = 1'b0;
        check("rstmid.no_done", 32'(n), 32'd0);
        access("rstmid.next", 1'b0, 2'b10, 1'b0, 32'h504, 32'h0, 32'h7654_3210, 0, 32'h0, 4'hF, 32'h7654_3210);

        // Memory never responds.
        MemReady = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h600, 32'h0);
`ifdef MEM_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            check("tmo.rd", 32'(MemRead), 32'd1);
            check("tmo.done_early", 32'(Done), 32'd0);
            step();
        end
        @(negedge Clk);
        check("tmo.done", 32'(Done), 32'd1);
        check("tmo.err", 32'(Error), 32'd1);
        check("tmo.mdr", 32'(MdrEnable), 32'd0);
        check("tmo.strobe", 32'(MemRead), 32'd0);
        check("tmo.load", LoadData, last_load);
        step();
`else
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge Clk);
            if (Done) n++;
            step();
        end
        check("hang.no_done", 32'(n), 32'd0);
        check("hang.busy", 32'(Busy), 32'd1);
        check("hang.rd", 32'(MemRead), 32'd1);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
`endif
        @(negedge Clk);
        check("end.idle", 32'(Busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameter DATA_SIZE, default 32, SHALL set the data and address width; only 32 is supported.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, SHALL set the wait-state limit used by REQ-027.
REQ-003 Ports SHALL be, in this order, one per line:
  Clk  in  1  single clock; all state changes on posedge.
  Rst  in  1  asynchronous, active-high reset.
  Req  in  1  start access; sampled only in IDLE.
  WrEn  in  1  1 = store, 0 = load; sampled with Req.
  Size  in  2  00 byte, 01 half, 10 word, 11 reserved; sampled with Req.
  Signed  in  1  sign-extend loads when 1; sampled with Req.
  Addr  in  32  byte address; sampled with Req.
  StoreData  in  32  store data, right-justified; sampled with Req.
  Busy  out  1  high whenever state is not IDLE.
  Done  out  1  one-cycle completion pulse.
  Error  out  1  valid with Done; misaligned, reserved Size or timeout.
  LoadData  out  32  aligned, extended load result; feeds the memory data register's WriteData.
  MdrEnable  out  1  write strobe for the memory data register's Enable.
  MemAddr  out  32  word address to memory, Addr with bits [1:0] forced to 0.
  MemWData  out  32  lane-replicated store data.
  MemBE  out  4  byte enables; bit k covers bits 8k+7:8k.
  MemRead  out  1  read strobe.
  MemWrite  out  1  write strobe.
  MemReady  in  1  memory completion; sampled while in ACCESS.
  MemRData  in  32  read data; valid in the cycle MemReady is high.
REQ-004 Clocking and reset are fixed: one clock; reset is asynchronous and active-high.

Function
REQ-005 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-006 IDLE SHALL go to ACCESS on Req=1 with a legal request, and SHALL register WrEn, Size, Signed, Addr and StoreData on that edge.
REQ-007 IDLE SHALL go to DONE with Error latched to 1 on Req=1 with Size=11, half with Addr[0]=1, or word with Addr[1:0]!=00; no Mem strobe SHALL be asserted for such a request.
REQ-008 In ACCESS, MemRead=~WrEn and MemWrite=WrEn SHALL be held, together with stable MemAddr, MemWData and MemBE, until MemReady=1 is sampled.
REQ-009 ACCESS SHALL go to DONE on the edge that samples MemReady=1, and the strobes SHALL deassert in DONE.
REQ-010 DONE SHALL last exactly one cycle with Done=1, then return to IDLE.
REQ-011 MdrEnable SHALL be 1 only in DONE for an error-free load; it SHALL be 0 for stores and for errored accesses.
REQ-012 Minimum latency SHALL be 2 cycles from the Req edge to Done, plus one cycle per cycle MemReady stays low.
REQ-013 Req while Busy=1 SHALL be ignored and not queued; Req in the DONE cycle SHALL also be ignored.
REQ-014 Lanes SHALL be little-endian: byte offset k=Addr[1:0] occupies bits 8k+7:8k.
REQ-015 Store byte: MemWData={4{StoreData[7:0]}}, MemBE=1<<k.
REQ-016 Store half: MemWData={2{StoreData[15:0]}}, MemBE=0011 for Addr[1]=0 and 1100 for Addr[1]=1.
REQ-017 Store word: MemWData=StoreData, MemBE=1111.
REQ-018 Loads SHALL drive MemBE=1111.
REQ-019 Load byte or half SHALL extract the selected lane of MemRData, then sign-extend when Signed=1 and zero-extend otherwise.
REQ-020 LoadData SHALL be registered on the MemReady edge and held until the next successful load completes.
REQ-021 Errored accesses SHALL leave LoadData unchanged.
REQ-022 Error SHALL be 0 whenever Done=0.

Reset
REQ-023 Asserting Rst SHALL force IDLE and clear all internal state immediately, without waiting for Clk.
REQ-024 During reset: Busy, Done, Error, MdrEnable, MemRead and MemWrite SHALL be 0; LoadData, MemAddr and MemWData SHALL be 0; MemBE SHALL be 0000.
REQ-025 Reset during ACCESS SHALL drop the strobes in the same cycle; the aborted access SHALL produce no Done.

Configuration
REQ-026 Macro MEM_TIMEOUT_EN SHALL compile in a wait-state watchdog.
REQ-027 With MEM_TIMEOUT_EN defined, a counter SHALL clear on entry to ACCESS; if MemReady is still 0 after TIMEOUT_CYCLES cycles in ACCESS, the FSM SHALL deassert the strobes and go to DONE with Error=1 and MdrEnable=0.
REQ-028 With MEM_TIMEOUT_EN undefined, ACCESS SHALL wait indefinitely, no counter logic SHALL exist, and Error SHALL arise only from REQ-007.

Verification
REQ-029 Load byte, Addr=0x103, Signed=1, MemRData=0x80FF_1234, MemReady high in the first ACCESS cycle -> MemAddr=0x100, Done and MdrEnable pulse at cycle 2, LoadData=0xFFFF_FF80.
REQ-030 Store half, Addr=0x22, StoreData=0x0000_BEEF, 3 wait states -> MemWData=0xBEEF_BEEF, MemBE=1100 held 4 cycles, Done at cycle 5, MdrEnable=0.
REQ-031 Load word, Addr=0x41 -> no MemRead, Done=1 and Error=1 at cycle 1, LoadData unchanged.
REQ-032 Rst asserted mid-ACCESS -> MemRead=0 before the next Clk edge; no Done after release; next Req completes normally.
REQ-033 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, MemReady held 0 -> strobe high for 4 cycles, then Done=1, Error=1; without the macro, no Done after 100 cycles.
REQ-034 Req held high continuously through two loads -> exactly two Done pulses, one IDLE cycle between them.
